// File: rtl/host_bus_if.sv
// host_bus_if: CPU register-bus front end driving the VRAM host port, with address auto-increment and a read prefetch register
//   clk, nrst                       dot clock, asynchronous active-low reset
//   busA, busDIn                    CPU register select and write data
//   busNCs, busNWr, busNRd          active-low bus strobes, asynchronous to clk
//   busDOut, busDOe                 CPU read data and its tri-state enable
//   hostAddr, hostWrData            VRAM host address and write data
//   hostSelect, hostRd, hostRdData  VRAM access strobe, direction (1 = read), read data one cycle after select
module host_bus_if #(
  parameter int ADDR_WIDTH  = 13,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [1:0]            busA,
  input  logic [7:0]            busDIn,
  input  logic                  busNCs,
  input  logic                  busNWr,
  input  logic                  busNRd,
  output logic [7:0]            busDOut,
  output logic                  busDOe,
  output logic [ADDR_WIDTH-1:0] hostAddr,
  output logic [7:0]            hostWrData,
  output logic                  hostSelect,
  output logic                  hostRd,
  input  logic [7:0]            hostRdData
);
  localparam logic [1:0] IDLE = 2'd0, WRITE = 2'd1, PREFETCH = 2'd2, CAPTURE = 2'd3;
  localparam int HW = ADDR_WIDTH - 8;
  logic [SYNC_STAGES-1:0] wr_sync, rd_sync;
  logic                   wr_s, rd_s, wr_d, rd_d, wr_ev, rd_ev, ev;
  logic [1:0]             state, state_nx, cap_a, pend_a, go_a;
  logic [7:0]             cap_d, pend_d, go_d, prefetch;
  logic                   pend_v, pend_w, auto_inc, overrun, busy, idle;
  logic                   go, go_w, store, drop, ctrl_wr, data_wr, data_rd;
  logic [ADDR_WIDTH-1:0]  addr;
  assign wr_s  = wr_sync[SYNC_STAGES-1];
  assign rd_s  = rd_sync[SYNC_STAGES-1];
  assign wr_ev = wr_d & ~wr_s;
  assign rd_ev = rd_d & ~rd_s;
  assign ev    = wr_ev | rd_ev;
  assign idle  = state == IDLE;
  // A waiting pending event always has priority over a fresh one; with the
  // slot still occupied the fresh event has nowhere to go and is dropped.
  assign go      = idle & (pend_v | ev);
  assign go_w    = pend_v ? pend_w : wr_ev;
  assign go_a    = pend_v ? pend_a : cap_a;
  assign go_d    = pend_v ? pend_d : cap_d;
  assign store   = ev & ~pend_v & ~idle;
  assign drop    = ev & pend_v;
  assign ctrl_wr = go & go_w & (go_a == 2'd3);
  assign data_wr = go & go_w & (go_a == 2'd2);
  assign data_rd = go & ~go_w & (go_a == 2'd2);
  assign state_nx = state == WRITE             ? PREFETCH :
                    state == PREFETCH          ? CAPTURE  :
                    state == CAPTURE || !go    ? IDLE     :
                    go_a == 2'd2               ? (go_w ? WRITE : PREFETCH) :
                    go_w && go_a != 2'd3       ? PREFETCH : IDLE;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_sync    <= '0;
      rd_sync    <= '0;
      wr_d       <= 1'b0;
      rd_d       <= 1'b0;
      cap_a      <= '0;
      cap_d      <= '0;
      pend_v     <= 1'b0;
      pend_w     <= 1'b0;
      pend_a     <= '0;
      pend_d     <= '0;
      state      <= IDLE;
      addr       <= '0;
      prefetch   <= '0;
      auto_inc   <= 1'b1;
      overrun    <= 1'b0;
      hostWrData <= '0;
    end else begin
      wr_sync <= SYNC_STAGES'({wr_sync, ~busNCs & ~busNWr});
      rd_sync <= SYNC_STAGES'({rd_sync, ~busNCs & ~busNRd});
      wr_d    <= wr_s;
      rd_d    <= rd_s;
      if (wr_s | rd_s) cap_a <= busA;
      if (wr_s) cap_d <= busDIn;
      if (store) {pend_v, pend_w, pend_a, pend_d} <= {1'b1, wr_ev, cap_a, cap_d};
      else if (go) pend_v <= 1'b0;
      state <= state_nx;
      if (state == WRITE || data_rd) addr <= addr + ADDR_WIDTH'(auto_inc);
      else if (go && go_w && go_a == 2'd0) addr[7:0] <= go_d;
      else if (go && go_w && go_a == 2'd1) addr[ADDR_WIDTH-1:8] <= go_d[HW-1:0];
      if (data_wr) hostWrData <= go_d;
      if (state == CAPTURE) prefetch <= hostRdData;
      if (ctrl_wr) auto_inc <= go_d[0];
      // a drop in the same cycle as a clear leaves overrun set
      overrun <= drop | (overrun & ~(ctrl_wr & go_d[7]));
    end
  end
  assign busy       = ~idle | pend_v;
  assign hostAddr   = addr;
  assign hostSelect = state == WRITE || state == PREFETCH;
  assign hostRd     = state != WRITE;
  assign busDOe     = ~busNCs & ~busNRd;
  assign busDOut    = busA == 2'd0 ? addr[7:0] :
                      busA == 2'd1 ? 8'(addr[ADDR_WIDTH-1:8]) :
                      busA == 2'd2 ? prefetch :
                      {overrun, busy, 5'b0, auto_inc};
endmodule

// File: tb/tb_host_bus_if.sv
// tb_host_bus_if: directed self-checking bench for host_bus_if with a behavioural VRAM
module tb_host_bus_if;
  logic        clk = 1'b0, nrst = 1'b0;
  logic [1:0]  busA = '0;
  logic [7:0]  busDIn = '0;
  logic        busNCs = 1'b1, busNWr = 1'b1, busNRd = 1'b1;
  logic [7:0]  busDOut, hostWrData;
  logic        busDOe, hostSelect, hostRd;
  logic [12:0] hostAddr;
  logic [7:0]  hostRdData = '0;
  logic [7:0]  mem [0:8191];
  logic        pl = 1'b0;
  logic [12:0] pl_a = '0, last_wa = '0, last_ra = '0;
  logic [7:0]  pl_d = '0, last_wd = '0, rv;
  int          wr_cnt = 0, rd_cnt = 0, n_chk = 0, n_fail = 0, base_w, base_r;

  always #5 clk = ~clk;

  host_bus_if #(.ADDR_WIDTH(13), .SYNC_STAGES(2)) dut (
    .clk(clk), .nrst(nrst), .busA(busA), .busDIn(busDIn),
    .busNCs(busNCs), .busNWr(busNWr), .busNRd(busNRd),
    .busDOut(busDOut), .busDOe(busDOe), .hostAddr(hostAddr),
    .hostWrData(hostWrData), .hostSelect(hostSelect), .hostRd(hostRd),
    .hostRdData(hostRdData)
  );

  always @(posedge clk) begin
    if (pl) mem[pl_a] <= pl_d;
    if (hostSelect && !hostRd) begin
      mem[hostAddr] <= hostWrData;
      wr_cnt  <= wr_cnt + 1;
      last_wa <= hostAddr;
      last_wd <= hostWrData;
    end
    if (hostSelect && hostRd) begin
      hostRdData <= mem[hostAddr];
      rd_cnt     <= rd_cnt + 1;
      last_ra    <= hostAddr;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [12:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_a = a; pl_d = d; pl = 1'b1;
    @(negedge clk);
    pl = 1'b0;
  endtask

  task automatic strobe_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    busA = a; busDIn = d; busNCs = 1'b0; busNWr = 1'b0;
    repeat (4) @(negedge clk);
    busNCs = 1'b1; busNWr = 1'b1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    strobe_wr(a, d);
    repeat (8) @(negedge clk);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    busA = a; busNCs = 1'b0; busNRd = 1'b0;
    repeat (3) @(negedge clk);
    chk("doe_on", 16'(busDOe), 16'h1);
    d = busDOut;
    @(negedge clk);
    busNCs = 1'b1; busNRd = 1'b1;
    #1 chk("doe_off", 16'(busDOe), 16'h0);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    // reset state
    chk("rst_sel", 16'(hostSelect), 16'h0);
    chk("rst_rd", 16'(hostRd), 16'h1);
    chk("rst_addr", 16'(hostAddr), 16'h0000);
    chk("rst_wdata", 16'(hostWrData), 16'h0000);
    busA = 2'd2;
    #1 chk("rst_prefetch", 16'(busDOut), 16'h0000);
    bus_read(2'd3, rv);
    chk("rst_ctrl", 16'(rv), 16'h0001);
    chk("rst_no_prefetch", 16'(rd_cnt), 16'h0);
    preload(13'h0123, 8'h55);
    preload(13'h0124, 8'h66);
    preload(13'h0200, 8'h5A);
    preload(13'h0201, 8'h7E);
    preload(13'h0300, 8'h33);
    // single write at 0x0123 with cycle-exact latency
    bus_write(2'd0, 8'h23);
    bus_write(2'd1, 8'h01);
    chk("addr_0123", 16'(hostAddr), 16'h0123);
    base_w = wr_cnt; base_r = rd_cnt;
    strobe_wr(2'd2, 8'h41);
    @(negedge clk); chk("wr_lat_n1", 16'(hostSelect), 16'h0);
    @(negedge clk); chk("wr_lat_n2", 16'(hostSelect), 16'h0);
    @(negedge clk);
    chk("wr_sel", 16'(hostSelect), 16'h1);
    chk("wr_dir", 16'(hostRd), 16'h0);
    chk("wr_addr", 16'(hostAddr), 16'h0123);
    chk("wr_data", 16'(hostWrData), 16'h0041);
    @(negedge clk);
    chk("pf_sel", 16'(hostSelect), 16'h1);
    chk("pf_dir", 16'(hostRd), 16'h1);
    chk("pf_addr", 16'(hostAddr), 16'h0124);
    @(negedge clk);
    chk("cap_sel", 16'(hostSelect), 16'h0);
    chk("pf_old", 16'(busDOut), 16'h0055);
    @(negedge clk);
    chk("pf_new", 16'(busDOut), 16'h0066);
    repeat (4) @(negedge clk);
    chk("wr_count", 16'(wr_cnt - base_w), 16'h1);
    chk("rd_count", 16'(rd_cnt - base_r), 16'h1);
    chk("mem_0123", 16'(mem[13'h0123]), 16'h0041);
    chk("last_ra", 16'(last_ra), 16'h0124);
    // prefetched data reads with auto-increment
    bus_write(2'd0, 8'h00);
    bus_write(2'd1, 8'h02);
    bus_read(2'd2, rv);
    chk("rd_5a", 16'(rv), 16'h005A);
    bus_read(2'd2, rv);
    chk("rd_7e", 16'(rv), 16'h007E);
    chk("addr_0202", 16'(hostAddr), 16'h0202);
    bus_read(2'd0, rv);
    chk("addr_lo_02", 16'(rv), 16'h0002);
    bus_read(2'd1, rv);
    chk("addr_hi_02", 16'(rv), 16'h0002);
    // wrap at top of address space and ADDR_HI masking
    bus_write(2'd0, 8'hFF);
    bus_write(2'd1, 8'h1F);
    bus_write(2'd2, 8'h11);
    chk("wrap_wa", 16'(last_wa), 16'h1FFF);
    chk("wrap_wd", 16'(last_wd), 16'h0011);
    chk("wrap_addr", 16'(hostAddr), 16'h0000);
    bus_write(2'd1, 8'hFF);
    bus_read(2'd1, rv);
    chk("hi_mask", 16'(rv), 16'h001F);
    chk("hi_keep_lo", 16'(hostAddr), 16'h1F00);
    // no auto-increment, then overrun from a too-fast burst
    bus_write(2'd3, 8'h00);
    bus_read(2'd3, rv);
    chk("ctrl_00", 16'(rv), 16'h0000);
    bus_write(2'd0, 8'h50);
    bus_write(2'd1, 8'h00);
    base_w = wr_cnt;
    bus_write(2'd2, 8'hAA);
    bus_write(2'd2, 8'hBB);
    chk("noinc_cnt", 16'(wr_cnt - base_w), 16'h2);
    chk("noinc_mem", 16'(mem[13'h0050]), 16'h00BB);
    chk("noinc_addr", 16'(hostAddr), 16'h0050);
    base_w = wr_cnt;
    @(negedge clk);
    busA = 2'd2; busDIn = 8'hCC;
    for (int i = 0; i < 3; i++) begin
      busNCs = 1'b0; busNWr = 1'b0;
      @(negedge clk);
      busNCs = 1'b1; busNWr = 1'b1;
      @(negedge clk);
    end
    repeat (12) @(negedge clk);
    chk("burst_cnt", 16'(wr_cnt - base_w), 16'h2);
    chk("burst_mem", 16'(mem[13'h0050]), 16'h00CC);
    bus_read(2'd3, rv);
    chk("overrun_set", 16'(rv), 16'h0080);
    bus_write(2'd3, 8'h81);
    bus_read(2'd3, rv);
    chk("overrun_clr", 16'(rv), 16'h0001);
    // reset in the middle of a DATA write
    bus_write(2'd0, 8'h00);
    bus_write(2'd1, 8'h03);
    base_w = wr_cnt; base_r = rd_cnt;
    strobe_wr(2'd2, 8'h99);
    repeat (2) @(negedge clk);
    nrst = 1'b0;
    #1;
    chk("abort_sel", 16'(hostSelect), 16'h0);
    chk("abort_rd", 16'(hostRd), 16'h1);
    chk("abort_addr", 16'(hostAddr), 16'h0000);
    chk("abort_wdata", 16'(hostWrData), 16'h0000);
    chk("abort_prefetch", 16'(busDOut), 16'h0000);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_no_wr", 16'(wr_cnt - base_w), 16'h0);
    chk("abort_no_rd", 16'(rd_cnt - base_r), 16'h0);
    chk("abort_mem", 16'(mem[13'h0300]), 16'h0033);
    bus_read(2'd3, rv);
    chk("abort_ctrl", 16'(rv), 16'h0001);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
